// File: rtl/cp0_regs.sv
// Coprocessor-0 register file with the Count/Compare timer.
// Ports:
//   clk, resetn        clock and asynchronous active-low reset
//   cp0_op             operation to commit this cycle (mutually exclusive kinds)
//   is_valid_exc       qualifies EXC/BADVA/TLB_EXC ops
//   exc_info           epc, branch-delay flag, exception code, bad virtual address
//   mtc0_addr/_wdata   MTC0 destination register and data
//   mfc0_addr/_rdata   combinational MFC0 read port (pre-edge values)
//   hw_int             level-sensitive external interrupt lines
//   tlbr_*             TLB entry returned for TLBR
//   tlbp_hit/_index    TLBP probe result
//   cp0_*              current architectural register values

package cp0_pkg;
    typedef enum logic [3:0] {
        Cp0OpNone,
        Cp0OpExc,
        Cp0OpBadva,
        Cp0OpTlbExc,
        Cp0OpEret,
        Cp0OpMtc0,
        Cp0OpTlbw,
        Cp0OpTlbr,
        Cp0OpTlbp
    } cp0_op_t;

    typedef struct packed {
        logic [31:0] epc;
        logic        cause_bd;
        logic [4:0]  cause_exccode;
        logic [31:0] badvaddr;
    } exc_info_t;
endpackage

module cp0_regs
    import cp0_pkg::*;
#(
    parameter int unsigned TLB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  cp0_op_t              cp0_op,
    input  logic                 is_valid_exc,
    input  exc_info_t            exc_info,
    input  logic [4:0]           mtc0_addr,
    input  logic [31:0]          mtc0_wdata,
    input  logic [4:0]           mfc0_addr,
    output logic [31:0]          mfc0_rdata,
    input  logic [5:0]           hw_int,
    input  logic [31:0]          tlbr_entryhi,
    input  logic [31:0]          tlbr_entrylo0,
    input  logic [31:0]          tlbr_entrylo1,
    input  logic                 tlbp_hit,
    input  logic [TLB_IDX_W-1:0] tlbp_index,
    output logic [31:0]          cp0_status,
    output logic [31:0]          cp0_cause,
    output logic [31:0]          cp0_epc,
    output logic [31:0]          cp0_entryhi,
    output logic [31:0]          cp0_index,
    output logic [31:0]          cp0_entrylo0,
    output logic [31:0]          cp0_entrylo1
);

    logic                 idx_p_q, idx_p_d;
    logic [TLB_IDX_W-1:0] idx_q, idx_d;
    logic [25:0]          lo0_q, lo0_d, lo1_q, lo1_d;
    logic [31:0]          badvaddr_q, badvaddr_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          compare_q, compare_d;
    logic [18:0]          vpn2_q, vpn2_d;
    logic [7:0]           asid_q, asid_d;
    logic [7:0]           im_q, im_d;
    logic                 exl_q, exl_d, ie_q, ie_d;
    logic                 bd_q, bd_d, ti_q, ti_d;
    logic [5:0]           ip_hw_q, ip_hw_d;
    logic [1:0]           ip_sw_q, ip_sw_d;
    logic [4:0]           exccode_q, exccode_d;
    logic [31:0]          epc_q, epc_d;
    logic                 tick_q, tick_d;

    // TLBR/TLB_EXC bits that fall outside the writable masks.
    logic unused_bits;
    assign unused_bits = ^{tlbr_entrylo0[31:26], tlbr_entrylo1[31:26], tlbr_entryhi[12:8]};

    always_comb begin
        idx_p_d    = idx_p_q;
        idx_d      = idx_q;
        lo0_d      = lo0_q;
        lo1_d      = lo1_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        vpn2_d     = vpn2_q;
        asid_d     = asid_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        tick_d     = ~tick_q;
        count_d    = count_q + {31'b0, tick_q};
        ti_d       = ti_q;

        if ((count_q == compare_q) && (compare_q != '0)) begin
            ti_d = 1'b1;
        end

        unique case (cp0_op)
            Cp0OpExc, Cp0OpBadva, Cp0OpTlbExc: begin
                if (is_valid_exc) begin
                    epc_d     = exc_info.epc;
                    bd_d      = exc_info.cause_bd;
                    exccode_d = exc_info.cause_exccode;
                    exl_d     = 1'b1;
                    if (cp0_op != Cp0OpExc) begin
                        badvaddr_d = exc_info.badvaddr;
                    end
                    if (cp0_op == Cp0OpTlbExc) begin
                        vpn2_d = exc_info.badvaddr[31:13];
                    end
                end
            end
            Cp0OpEret: exl_d = 1'b0;
            Cp0OpMtc0: begin
                case (mtc0_addr)
                    5'd0:  idx_d = mtc0_wdata[TLB_IDX_W-1:0];
                    5'd2:  lo0_d = mtc0_wdata[25:0];
                    5'd3:  lo1_d = mtc0_wdata[25:0];
                    5'd9:  count_d = mtc0_wdata;  // overrides this cycle's increment
                    5'd10: begin
                        vpn2_d = mtc0_wdata[31:13];
                        asid_d = mtc0_wdata[7:0];
                    end
                    5'd11: begin
                        compare_d = mtc0_wdata;
                        ti_d      = 1'b0;  // clear beats a same-cycle match
                    end
                    5'd12: begin
                        im_d  = mtc0_wdata[15:8];
                        exl_d = mtc0_wdata[1];
                        ie_d  = mtc0_wdata[0];
                    end
                    5'd13: ip_sw_d = mtc0_wdata[9:8];
                    5'd14: epc_d = mtc0_wdata;
                    default: ;
                endcase
            end
            Cp0OpTlbr: begin
                vpn2_d = tlbr_entryhi[31:13];
                asid_d = tlbr_entryhi[7:0];
                lo0_d  = tlbr_entrylo0[25:0];
                lo1_d  = tlbr_entrylo1[25:0];
            end
            Cp0OpTlbp: begin
                idx_p_d = ~tlbp_hit;
                idx_d   = tlbp_hit ? tlbp_index : '0;
            end
            Cp0OpNone, Cp0OpTlbw: ;
            default: ;
        endcase

        // IP7 carries the timer interrupt alongside hw_int[5].
        ip_hw_d = {hw_int[5] | ti_d, hw_int[4:0]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_p_q    <= 1'b0;
            idx_q      <= '0;
            lo0_q      <= '0;
            lo1_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            vpn2_q     <= '0;
            asid_q     <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            epc_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            idx_p_q    <= idx_p_d;
            idx_q      <= idx_d;
            lo0_q      <= lo0_d;
            lo1_q      <= lo1_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            vpn2_q     <= vpn2_d;
            asid_q     <= asid_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            tick_q     <= tick_d;
        end
    end

    // BEV (bit 22) is hardwired to 1.
    assign cp0_status   = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cp0_cause    = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
    assign cp0_epc      = epc_q;
    assign cp0_entryhi  = {vpn2_q, 5'b0, asid_q};
    assign cp0_index    = {idx_p_q, {(31 - TLB_IDX_W){1'b0}}, idx_q};
    assign cp0_entrylo0 = {6'b0, lo0_q};
    assign cp0_entrylo1 = {6'b0, lo1_q};

    always_comb begin
        mfc0_rdata = '0;
        case (mfc0_addr)
            5'd0:  mfc0_rdata = cp0_index;
            5'd2:  mfc0_rdata = cp0_entrylo0;
            5'd3:  mfc0_rdata = cp0_entrylo1;
            5'd8:  mfc0_rdata = badvaddr_q;
            5'd9:  mfc0_rdata = count_q;
            5'd10: mfc0_rdata = cp0_entryhi;
            5'd11: mfc0_rdata = compare_q;
            5'd12: mfc0_rdata = cp0_status;
            5'd13: mfc0_rdata = cp0_cause;
            5'd14: mfc0_rdata = epc_q;
            default: mfc0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Randomized scoreboard bench for cp0_regs against a register-array reference model.
module tb_cp0_regs;
    import cp0_pkg::*;

    localparam int unsigned TlbIdxW = 4;

    logic               clk;
    logic               resetn;
    cp0_op_t            cp0_op;
    logic               is_valid_exc;
    exc_info_t          exc_info;
    logic [4:0]         mtc0_addr;
    logic [31:0]        mtc0_wdata;
    logic [4:0]         mfc0_addr;
    logic [31:0]        mfc0_rdata;
    logic [5:0]         hw_int;
    logic [31:0]        tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1;
    logic               tlbp_hit;
    logic [TlbIdxW-1:0] tlbp_index;
    logic [31:0]        cp0_status, cp0_cause, cp0_epc, cp0_entryhi;
    logic [31:0]        cp0_index, cp0_entrylo0, cp0_entrylo1;

    cp0_regs #(.TLB_IDX_W(TlbIdxW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cp0_op       (cp0_op),
        .is_valid_exc (is_valid_exc),
        .exc_info     (exc_info),
        .mtc0_addr    (mtc0_addr),
        .mtc0_wdata   (mtc0_wdata),
        .mfc0_addr    (mfc0_addr),
        .mfc0_rdata   (mfc0_rdata),
        .hw_int       (hw_int),
        .tlbr_entryhi (tlbr_entryhi),
        .tlbr_entrylo0(tlbr_entrylo0),
        .tlbr_entrylo1(tlbr_entrylo1),
        .tlbp_hit     (tlbp_hit),
        .tlbp_index   (tlbp_index),
        .cp0_status   (cp0_status),
        .cp0_cause    (cp0_cause),
        .cp0_epc      (cp0_epc),
        .cp0_entryhi  (cp0_entryhi),
        .cp0_index    (cp0_index),
        .cp0_entrylo0 (cp0_entrylo0),
        .cp0_entrylo1 (cp0_entrylo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        cp0_op_t     op;
        logic        valid;
        logic [31:0] epc;
        logic        bd;
        logic [4:0]  code;
        logic [31:0] badva;
        logic [4:0]  maddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [5:0]  hw;
        logic [31:0] ehi;
        logic [31:0] elo0;
        logic [31:0] elo1;
        logic        hit;
        logic [3:0]  pidx;
    } stim_t;

    typedef struct packed {
        logic [31:0] status, cause, epc, entryhi, index, lo0, lo1, rdata;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural registers indexed by CP0 number.
    logic [31:0] m_reg [32];
    logic        m_tick;
    logic        m_ti;

    function automatic logic [31:0] wmask(input logic [4:0] a);
        case (a)
            5'd0:              return 32'h0000_000F;
            5'd2, 5'd3:        return 32'h03FF_FFFF;
            5'd9, 5'd11, 5'd14: return 32'hFFFF_FFFF;
            5'd10:             return 32'hFFFF_E0FF;
            5'd12:             return 32'h0000_FF03;
            5'd13:             return 32'h0000_0300;
            default:           return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd0, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: return m_reg[a];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_reg[12] = 32'h0040_0000;
        m_tick = 1'b0;
        m_ti   = 1'b0;
    endtask

    task automatic model_step(input stim_t s);
        logic [31:0] old_count, old_compare;
        logic        match;
        old_count   = m_reg[9];
        old_compare = m_reg[11];
        match       = (old_count == old_compare) && (old_compare != 0);
        if (m_tick) m_reg[9] = old_count + 1;
        if (s.valid && (s.op == Cp0OpExc || s.op == Cp0OpBadva || s.op == Cp0OpTlbExc)) begin
            m_reg[14]      = s.epc;
            m_reg[13][31]  = s.bd;
            m_reg[13][6:2] = s.code;
            m_reg[12][1]   = 1'b1;
            if (s.op != Cp0OpExc) m_reg[8] = s.badva;
            if (s.op == Cp0OpTlbExc) m_reg[10][31:13] = s.badva[31:13];
        end
        if (s.op == Cp0OpEret) m_reg[12][1] = 1'b0;
        if (s.op == Cp0OpMtc0)
            m_reg[s.maddr] = (m_reg[s.maddr] & ~wmask(s.maddr)) | (s.wdata & wmask(s.maddr));
        if (s.op == Cp0OpTlbr) begin
            m_reg[10] = s.ehi & 32'hFFFF_E0FF;
            m_reg[2]  = s.elo0 & 32'h03FF_FFFF;
            m_reg[3]  = s.elo1 & 32'h03FF_FFFF;
        end
        if (s.op == Cp0OpTlbp) m_reg[0] = s.hit ? {28'h0, s.pidx} : 32'h8000_0000;
        if (s.op == Cp0OpMtc0 && s.maddr == 5'd11) m_ti = 1'b0;
        else if (match) m_ti = 1'b1;
        m_reg[13][30]    = m_ti;
        m_reg[13][15:10] = {s.hw[5] | m_ti, s.hw[4:0]};
        m_tick = ~m_tick;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        cp0_op                 = s.op;
        is_valid_exc           = s.valid;
        exc_info.epc           = s.epc;
        exc_info.cause_bd      = s.bd;
        exc_info.cause_exccode = s.code;
        exc_info.badvaddr      = s.badva;
        mtc0_addr              = s.maddr;
        mtc0_wdata             = s.wdata;
        mfc0_addr              = s.raddr;
        hw_int                 = s.hw;
        tlbr_entryhi           = s.ehi;
        tlbr_entrylo0          = s.elo0;
        tlbr_entrylo1          = s.elo1;
        tlbp_hit               = s.hit;
        tlbp_index             = s.pidx;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic apply(input stim_t s);
        exp_t e;
        drive(s);
        model_step(s);
        e.status  = m_reg[12];
        e.cause   = m_reg[13];
        e.epc     = m_reg[14];
        e.entryhi = m_reg[10];
        e.index   = m_reg[0];
        e.lo0     = m_reg[2];
        e.lo1     = m_reg[3];
        e.rdata   = m_read(s.raddr);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Holds resetn low across one rising edge while s is presented, then releases it.
    task automatic do_reset(input stim_t s);
        drive(s);
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_status", cp0_status, m_reg[12]);
        chk("rst_cause", cp0_cause, 32'h0);
        chk("rst_epc", cp0_epc, 32'h0);
        chk("rst_entryhi", cp0_entryhi, 32'h0);
        chk("rst_index", cp0_index, 32'h0);
        chk("rst_lo0", cp0_entrylo0, 32'h0);
        chk("rst_lo1", cp0_entrylo1, 32'h0);
        chk("rst_mfc0", mfc0_rdata, m_read(s.raddr));
        @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic stim_t idle(input logic [4:0] raddr);
        stim_t s;
        s       = '0;
        s.op    = Cp0OpNone;
        s.raddr = raddr;
        return s;
    endfunction

    function automatic stim_t mtc0(input logic [4:0] a, input logic [31:0] d,
                                   input logic [4:0] raddr);
        stim_t s;
        s       = idle(raddr);
        s.op    = Cp0OpMtc0;
        s.maddr = a;
        s.wdata = d;
        return s;
    endfunction

    // Monitor: compare every committed cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("status", cp0_status, e.status);
                chk("cause", cp0_cause, e.cause);
                chk("epc", cp0_epc, e.epc);
                chk("entryhi", cp0_entryhi, e.entryhi);
                chk("index", cp0_index, e.index);
                chk("entrylo0", cp0_entrylo0, e.lo0);
                chk("entrylo1", cp0_entrylo1, e.lo1);
                chk("mfc0", mfc0_rdata, e.rdata);
            end
        end
    end

    initial begin
        stim_t s;
        logic [4:0] addr_tbl [9];
        addr_tbl = '{5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
        resetn = 1'b0;
        model_reset();
        drive(idle(5'd0));

        // Reset and idle: Count advances every second cycle.
        do_reset(idle(5'd9));
        for (int i = 0; i < 10; i++) apply(idle(5'd9));
        chk("count_after_10", mfc0_rdata, 32'd5);
        chk("status_reset", cp0_status, 32'h0040_0000);
        chk("cause_idle", cp0_cause, 32'h0);

        // Timer interrupt raise and clear.
        do_reset(idle(5'd13));
        apply(mtc0(5'd11, 32'd3, 5'd9));
        for (int i = 0; i < 5; i++) apply(idle(5'd9));
        chk("ti_before", cp0_cause, 32'h0);
        apply(idle(5'd9));
        chk("ti_set", cp0_cause, 32'h4000_8000);
        apply(mtc0(5'd11, 32'h100, 5'd13));
        chk("ti_clear", cp0_cause, 32'h0);

        // BADVA exception then ERET.
        s = idle(5'd8);
        s.op = Cp0OpBadva; s.valid = 1'b1; s.epc = 32'hBFC0_0100;
        s.badva = 32'h1234_5671; s.code = 5'd4;
        apply(s);
        chk("badva_epc", cp0_epc, 32'hBFC0_0100);
        chk("badva_rd", mfc0_rdata, 32'h1234_5671);
        chk("badva_code", {27'h0, cp0_cause[6:2]}, 32'd4);
        chk("badva_exl", cp0_status, 32'h0040_0002);
        s = idle(5'd14);
        s.op = Cp0OpEret;
        apply(s);
        chk("eret_exl", cp0_status, 32'h0040_0000);
        chk("eret_epc", mfc0_rdata, 32'hBFC0_0100);

        // TLB exception keeps ASID; TLBP miss and hit.
        apply(mtc0(5'd10, 32'h0000_002A, 5'd10));
        s = idle(5'd10);
        s.op = Cp0OpTlbExc; s.valid = 1'b1; s.badva = 32'h8765_4000;
        apply(s);
        chk("tlbexc_ehi", cp0_entryhi, 32'h8765_402A);
        s = idle(5'd0);
        s.op = Cp0OpTlbp; s.hit = 1'b0; s.pidx = 4'd9;
        apply(s);
        chk("tlbp_miss", cp0_index, 32'h8000_0000);
        s.hit = 1'b1; s.pidx = 4'd5;
        apply(s);
        chk("tlbp_hit", mfc0_rdata, 32'd5);

        // Write masks.
        apply(mtc0(5'd12, 32'hFFFF_FFFF, 5'd12));
        chk("status_mask", cp0_status, 32'h0040_FF03);
        do_reset(idle(5'd13));
        apply(mtc0(5'd13, 32'hFFFF_FFFF, 5'd13));
        chk("cause_mask", cp0_cause, 32'h0000_0300);
        apply(mtc0(5'd8, 32'hDEAD_BEEF, 5'd8));
        chk("badva_ro", mfc0_rdata, 32'h0);

        // Reset asserted during an exception commit.
        apply(mtc0(5'd12, 32'h0000_0003, 5'd12));
        s = idle(5'd12);
        s.op = Cp0OpExc; s.valid = 1'b1; s.epc = 32'h0000_ABCD; s.code = 5'd8;
        do_reset(s);
        apply(idle(5'd12));
        chk("post_rst_status", cp0_status, 32'h0040_0000);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            s       = '0;
            s.op    = cp0_op_t'($urandom_range(0, 8));
            s.valid = 1'($urandom_range(0, 1));
            s.epc   = $urandom;
            s.bd    = 1'($urandom_range(0, 1));
            s.code  = 5'($urandom_range(0, 31));
            s.badva = $urandom;
            if ($urandom_range(0, 9) == 9) s.maddr = 5'($urandom_range(1, 31));
            else s.maddr = addr_tbl[$urandom_range(0, 8)];
            s.wdata = $urandom;
            if ((s.maddr == 5'd9 || s.maddr == 5'd11) && $urandom_range(0, 1) == 1)
                s.wdata = $urandom_range(0, 32);
            s.raddr = 5'($urandom_range(0, 31));
            s.hw    = 6'($urandom_range(0, 63));
            s.ehi   = $urandom;
            s.elo0  = $urandom;
            s.elo1  = $urandom;
            s.hit   = 1'($urandom_range(0, 1));
            s.pidx  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) do_reset(s);
            else apply(s);
        end

        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
